wb_regfile: RTL and testbench
=============================

# wb_regfile

Parametrised write-back stage with integrated register file for the 5-stage pipeline. It replaces the fixed 8×16-bit write-back unit. One staging register sits between MEM and WB, so write-back is a true pipeline stage. Result selection (ALU vs memory) is by opcode class, and the register file is owned inside the block, with read-port bypass of the pending commit. It also adds stall and flush controls, a retired-instruction counter and a sticky illegal-destination flag.

## Interface
- DATA_W, 16, register and datapath width
- NUM_REGS, 8, number of architectural registers (≥2)
- RD_W, 4, destination/source index width (2^RD_W ≥ NUM_REGS)
- CNT_W, 16, retired counter width
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  MEM stage presents an instruction this cycle
- instruction  in  4  opcode of presented instruction
- alu_output  in  DATA_W  ALU result
- data_from_mem  in  DATA_W  load data
- reg_nos  in  RD_W  destination register index
- stall  in  1  hold stage register, suppress commit
- flush  in  1  discard staged instruction
- rs1, rs2  in  RD_W  read-port indices
- rs1_data, rs2_data  out  DATA_W  read data, bypassed
- reg_flat  out  NUM_REGS*DATA_W  all registers, reg i at bits [i*DATA_W +: DATA_W]
- retired  out  CNT_W  committed-instruction count
- err_rd  out  1  sticky: illegal destination seen

## Operation
- Opcode classes:
  - 4'b0011 LOAD, writes data_from_mem.
  - 4'b1000–4'b1111 no-write (store/branch/jump/nop).
  - All others ALU, write alu_output.
- Capture, at an edge with flush=0 and stall=0:
  - stage_valid ← wb_valid.
  - If wb_valid: stage_we ← (class writes) && (reg_nos < NUM_REGS), stage_rd ← reg_nos, stage_data ← selected source.
  - Selection happens at capture; only one DATA_W value is stored.
- Commit, at an edge with stage_valid=1, stall=0, flush=0:
  - If stage_we: regs[stage_rd] ← stage_data.
  - retired ← retired+1, for every committed instruction including no-write ones. Wraps modulo 2^CNT_W, no saturation.
  - Capture and commit at the same edge form normal pipelined flow: the old stage commits and the new one loads.
- Illegal destination: a writing class with reg_nos ≥ NUM_REGS sets err_rd at commit. That instruction is still counted as retired, and no register changes. err_rd clears only on reset.
- Stall=1, flush=0: stage register, regs and retired hold. Inputs that cycle are ignored; upstream holds them.
- Flush=1: stage_valid ← 0 with no commit, and flush has priority over stall. Inputs that cycle are not captured.
- Read ports are combinational:
  - rsX_data = stage_data if stage_valid && stage_we && stage_rd==rsX; otherwise regs[rsX].
  - rsX ≥ NUM_REGS reads 0.
- reg_flat shows committed state only, with no bypass.
- Reset, asynchronous while rst_n=0: all regs=0, stage_valid=0, stage_we=0, retired=0, err_rd=0; rs1_data/rs2_data=0. A staged instruction is lost if reset hits mid-operation.

## Timing
- Latency: an instruction presented before edge E is captured at E and committed at E+1. reg_flat shows it after E+1, and rsX_data shows it (bypassed) right after E.
- Back-to-back writes to the same rd: each edge commits the older one; the bypass always returns the youngest staged value.
- Stall for k cycles delays the commit by exactly k edges.
- Stall and flush together: flush wins, and the staged instruction is dropped, not committed.
- No combinational path from wb_valid, instruction or alu_output to any output except through the stage register. Read data depends combinationally on rs1/rs2 and state only.

## Test plan
- Reset, then ALU op 4'b0000, alu_output=16'h000D, reg_nos=0 → rs1=0 reads 16'h000D one edge later (bypass). reg_flat[15:0]=16'h000D after second edge. retired=1.
- Back-to-back writes to r0: LOAD 4'b0011 with data_from_mem=16'h000F, then ALU with alu_output=16'h0003 → after both commit r0=16'h0003, and rs1=0 returned 16'h000F in the cycle between.
- Store 4'b1000 to reg_nos=2 with alu_output=16'hFFFF → r2 stays 0 and retired increments by 1.
- Stage LOAD to r5 with 16'h1234, assert stall 3 cycles → r5 stays 0 while bypass returns 16'h1234. Commit occurs at the first edge after stall drops.
- Stage ALU to r3, assert flush with stall=1 → r3 stays 0, retired unchanged. Then ALU to reg_nos=9 (NUM_REGS=8) → err_rd=1 and sticky, retired+1, reg_flat unchanged.
- Drive rst_n low mid-stall with r1=16'hABCD staged → all outputs 0 immediately, and no commit after release.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB staging register, write-back commit and register file.
// An instruction is captured into the stage register at one edge and
// committed at the next. Read ports bypass the pending commit.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb_valid, instruction       MEM presents an instruction / its opcode
//   alu_output, data_from_mem   candidate write-back values
//   reg_nos                     destination index
//   stall, flush                hold stage / discard staged instruction
//   rs1, rs2 -> rs1_data, rs2_data   combinational read ports (bypassed)
//   reg_flat                    committed registers, reg i at [i*DATA_W +: DATA_W]
//   retired                     committed-instruction counter (wraps)
//   err_rd                      sticky illegal-destination flag
module wb_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned RD_W     = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    input  logic [3:0]                 instruction,
    input  logic [DATA_W-1:0]          alu_output,
    input  logic [DATA_W-1:0]          data_from_mem,
    input  logic [RD_W-1:0]            reg_nos,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [RD_W-1:0]            rs1,
    input  logic [RD_W-1:0]            rs2,
    output logic [DATA_W-1:0]          rs1_data,
    output logic [DATA_W-1:0]          rs2_data,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    output logic [CNT_W-1:0]           retired,
    output logic                       err_rd
);

    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]  OP_LOAD = 4'b0011;

    logic                               stage_valid;
    logic                               stage_we;
    logic                               stage_bad;
    logic [RD_W-1:0]                    stage_rd;
    logic [DATA_W-1:0]                  stage_data;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs;

    logic                               advance_c;
    logic                               commit_c;
    logic                               class_writes_c;
    logic                               rd_ok_c;
    logic [DATA_W-1:0]                  sel_data_c;

    // Opcodes 1xxx never write; everything else writes ALU or load data.
    assign class_writes_c = ~instruction[3];
    assign rd_ok_c        = (32'(reg_nos) < NUM_REGS);
    assign sel_data_c     = (instruction == OP_LOAD) ? data_from_mem : alu_output;
    assign advance_c      = ~flush & ~stall;
    assign commit_c       = stage_valid & advance_c;

    // Stage register; flush wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_we    <= 1'b0;
            stage_bad   <= 1'b0;
            stage_rd    <= '0;
            stage_data  <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else if (!stall) begin
            stage_valid <= wb_valid;
            if (wb_valid) begin
                stage_we   <= class_writes_c & rd_ok_c;
                stage_bad  <= class_writes_c & ~rd_ok_c;
                stage_rd   <= reg_nos;
                stage_data <= sel_data_c;
            end
        end
    end

    // Register file commit; stage_we is only set for in-range destinations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (commit_c && stage_we) begin
            regs[stage_rd[IDX_W-1:0]] <= stage_data;
        end
    end

    // Retired counter and sticky error, both updated at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            err_rd  <= 1'b0;
        end else if (commit_c) begin
            retired <= retired + CNT_W'(1);
            if (stage_bad) begin
                err_rd <= 1'b1;
            end
        end
    end

    // Read port 1: youngest staged value first, then committed state.
    always_comb begin
        rs1_data = '0;
        if (stage_valid && stage_we && (stage_rd == rs1)) begin
            rs1_data = stage_data;
        end else if (32'(rs1) < NUM_REGS) begin
            rs1_data = regs[rs1[IDX_W-1:0]];
        end
    end

    // Read port 2: same bypass rule as port 1.
    always_comb begin
        rs2_data = '0;
        if (stage_valid && stage_we && (stage_rd == rs2)) begin
            rs2_data = stage_data;
        end else if (32'(rs2) < NUM_REGS) begin
            rs2_data = regs[rs2[IDX_W-1:0]];
        end
    end

    assign reg_flat = regs;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed scenarios plus randomized traffic
// checked against a behavioural model of the stage and register file.
module tb_wb_regfile;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_valid;
    logic [3:0]        instruction;
    logic [DW-1:0]     alu_output;
    logic [DW-1:0]     data_from_mem;
    logic [RW-1:0]     reg_nos;
    logic              stall;
    logic              flush;
    logic [RW-1:0]     rs1;
    logic [RW-1:0]     rs2;
    logic [DW-1:0]     rs1_data;
    logic [DW-1:0]     rs2_data;
    logic [NR*DW-1:0]  reg_flat;
    logic [CW-1:0]     retired;
    logic              err_rd;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile #(.DATA_W(DW), .NUM_REGS(NR), .RD_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .instruction(instruction),
        .alu_output(alu_output), .data_from_mem(data_from_mem), .reg_nos(reg_nos),
        .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .reg_flat(reg_flat),
        .retired(retired), .err_rd(err_rd)
    );

    always #5 clk = ~clk;

    // Behavioural model: one pending instruction plus architectural state.
    logic [DW-1:0] m_regs [16];
    logic          m_v;
    logic          m_wr;
    logic [3:0]    m_rd;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_ret;
    logic          m_err;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_v = 1'b0; m_wr = 1'b0; m_rd = '0; m_data = '0; m_ret = '0; m_err = 1'b0;
    endfunction

    // One clock edge: retire the pending instruction, then accept the new one.
    function automatic void model_edge();
        if (flush) begin
            m_v = 1'b0;
        end else if (!stall) begin
            if (m_v) begin
                if (m_wr) begin
                    if (m_rd < 4'(NR)) m_regs[m_rd] = m_data;
                    else m_err = 1'b1;
                end
                m_ret = m_ret + 1'b1;
            end
            m_v = wb_valid;
            if (wb_valid) begin
                m_wr   = (instruction < 4'd8);
                m_rd   = reg_nos;
                m_data = (instruction == 4'd3) ? data_from_mem : alu_output;
            end
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [3:0] rs);
        if (m_v && m_wr && (m_rd < 4'(NR)) && (m_rd == rs)) return m_data;
        if (rs < 4'(NR)) return m_regs[rs];
        return '0;
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = m_regs[i];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instruction = 4'hF; alu_output = '0; data_from_mem = '0; reg_nos = '0;
    endtask

    task automatic present(input logic [3:0] op, input logic [DW-1:0] alu,
                           input logic [DW-1:0] mem, input logic [3:0] rd);
        wb_valid = 1'b1; instruction = op; alu_output = alu;
        data_from_mem = mem; reg_nos = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); rs1 = 4'd0; rs2 = 4'd7;
        #12;
        n_tests++; if (reg_flat !== '0) begin n_fail++; $display("FAIL reset_flat got %h want 0", reg_flat); end
        n_tests++; if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
        n_tests++; if (err_rd !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_rd); end
        n_tests++; if (rs1_data !== '0 || rs2_data !== '0) begin n_fail++; $display("FAIL reset_rs got %h/%h want 0/0", rs1_data, rs2_data); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_alu_bypass();
        present(4'b0000, 16'h000D, 16'h7777, 4'd0);
        step();
        idle(); rs1 = 4'd0; #1;
        n_tests++; if (rs1_data !== 16'h000D) begin n_fail++; $display("FAIL alu_bypass got %h want 000d", rs1_data); end
        n_tests++; if (reg_flat[15:0] !== 16'h0000) begin n_fail++; $display("FAIL alu_precommit got %h want 0000", reg_flat[15:0]); end
        step();
        n_tests++; if (reg_flat[15:0] !== 16'h000D) begin n_fail++; $display("FAIL alu_commit got %h want 000d", reg_flat[15:0]); end
        n_tests++; if (retired !== 16'd1) begin n_fail++; $display("FAIL alu_retired got %0d want 1", retired); end
    endtask

    task automatic test_back_to_back();
        present(4'b0011, 16'h1111, 16'h000F, 4'd0);
        step();
        present(4'b0001, 16'h0003, 16'h2222, 4'd0); rs1 = 4'd0; #1;
        n_tests++; if (rs1_data !== 16'h000F) begin n_fail++; $display("FAIL b2b_bypass_load got %h want 000f", rs1_data); end
        step();
        idle(); #1;
        n_tests++; if (reg_flat[15:0] !== 16'h000F) begin n_fail++; $display("FAIL b2b_first_commit got %h want 000f", reg_flat[15:0]); end
        n_tests++; if (rs1_data !== 16'h0003) begin n_fail++; $display("FAIL b2b_youngest got %h want 0003", rs1_data); end
        step();
        n_tests++; if (reg_flat[15:0] !== 16'h0003) begin n_fail++; $display("FAIL b2b_final got %h want 0003", reg_flat[15:0]); end
        n_tests++; if (retired !== 16'd3) begin n_fail++; $display("FAIL b2b_retired got %0d want 3", retired); end
    endtask

    task automatic test_store();
        logic [CW-1:0] r0;
        r0 = retired;
        present(4'b1000, 16'hFFFF, 16'hFFFF, 4'd2);
        step();
        idle(); rs2 = 4'd2; #1;
        n_tests++; if (rs2_data !== 16'h0000) begin n_fail++; $display("FAIL store_nobypass got %h want 0000", rs2_data); end
        step();
        n_tests++; if (reg_flat[2*DW +: DW] !== 16'h0000) begin n_fail++; $display("FAIL store_r2 got %h want 0000", reg_flat[2*DW +: DW]); end
        n_tests++; if (retired !== r0 + 1'b1) begin n_fail++; $display("FAIL store_retired got %0d want %0d", retired, r0 + 1'b1); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] r0;
        present(4'b0011, 16'hAAAA, 16'h1234, 4'd5);
        step();
        r0 = retired;
        present(4'b0000, 16'hBEEF, 16'hBEEF, 4'd5); stall = 1'b1; rs1 = 4'd5;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (reg_flat[5*DW +: DW] !== 16'h0000) begin n_fail++; $display("FAIL stall_r5_cyc%0d got %h want 0000", k, reg_flat[5*DW +: DW]); end
            n_tests++; if (rs1_data !== 16'h1234) begin n_fail++; $display("FAIL stall_bypass_cyc%0d got %h want 1234", k, rs1_data); end
            n_tests++; if (retired !== r0) begin n_fail++; $display("FAIL stall_retired_cyc%0d got %0d want %0d", k, retired, r0); end
        end
        idle();
        step();
        n_tests++; if (reg_flat[5*DW +: DW] !== 16'h1234) begin n_fail++; $display("FAIL stall_release got %h want 1234", reg_flat[5*DW +: DW]); end
        n_tests++; if (retired !== r0 + 1'b1) begin n_fail++; $display("FAIL stall_release_ret got %0d want %0d", retired, r0 + 1'b1); end
    endtask

    task automatic test_flush_err();
        logic [CW-1:0]    r0;
        logic [NR*DW-1:0] f0;
        present(4'b0010, 16'h5555, 16'h0000, 4'd3);
        step();
        r0 = retired;
        present(4'b0000, 16'h6666, 16'h0000, 4'd4); flush = 1'b1; stall = 1'b1;
        step();
        idle(); rs1 = 4'd3; rs2 = 4'd4;
        step();
        n_tests++; if (reg_flat[3*DW +: DW] !== 16'h0000 || rs1_data !== 16'h0000) begin n_fail++; $display("FAIL flush_r3 got %h/%h want 0000", reg_flat[3*DW +: DW], rs1_data); end
        n_tests++; if (reg_flat[4*DW +: DW] !== 16'h0000) begin n_fail++; $display("FAIL flush_nocapture got %h want 0000", reg_flat[4*DW +: DW]); end
        n_tests++; if (retired !== r0) begin n_fail++; $display("FAIL flush_retired got %0d want %0d", retired, r0); end
        f0 = reg_flat;
        present(4'b0100, 16'h9999, 16'h0000, 4'd9);
        step();
        idle(); rs1 = 4'd9; #1;
        n_tests++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL err_read_oob got %h want 0000", rs1_data); end
        n_tests++; if (err_rd !== 1'b0) begin n_fail++; $display("FAIL err_early got %b want 0", err_rd); end
        step();
        n_tests++; if (err_rd !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err_rd); end
        n_tests++; if (retired !== r0 + 1'b1) begin n_fail++; $display("FAIL err_retired got %0d want %0d", retired, r0 + 1'b1); end
        n_tests++; if (reg_flat !== f0) begin n_fail++; $display("FAIL err_flat got %h want %h", reg_flat, f0); end
        present(4'b0000, 16'h0001, 16'h0000, 4'd1);
        step(); idle(); step(); step();
        n_tests++; if (err_rd !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err_rd); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            wb_valid      = ($urandom_range(0, 3) != 0);
            instruction   = 4'($urandom);
            alu_output    = 16'($urandom);
            data_from_mem = 16'($urandom);
            reg_nos       = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            stall         = (r < 20);
            flush         = (r >= 90);
            step();
            rs1 = 4'($urandom); rs2 = 4'($urandom_range(0, 7)); #1;
            n_tests++; if (rs1_data !== model_read(rs1)) begin n_fail++; $display("FAIL rand_rs1 n=%0d rs1=%0d got %h want %h", n, rs1, rs1_data, model_read(rs1)); end
            n_tests++; if (rs2_data !== model_read(rs2)) begin n_fail++; $display("FAIL rand_rs2 n=%0d rs2=%0d got %h want %h", n, rs2, rs2_data, model_read(rs2)); end
            n_tests++; if (reg_flat !== model_flat()) begin n_fail++; $display("FAIL rand_flat n=%0d got %h want %h", n, reg_flat, model_flat()); end
            n_tests++; if (retired !== m_ret) begin n_fail++; $display("FAIL rand_retired n=%0d got %0d want %0d", n, retired, m_ret); end
            n_tests++; if (err_rd !== m_err) begin n_fail++; $display("FAIL rand_err n=%0d got %b want %b", n, err_rd, m_err); end
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        present(4'b0001, 16'hABCD, 16'h0000, 4'd1);
        step();
        idle(); stall = 1'b1;
        step();
        rs1 = 4'd1; #1;
        n_tests++; if (rs1_data !== 16'hABCD) begin n_fail++; $display("FAIL rst_pre_bypass got %h want abcd", rs1_data); end
        rst_n = 1'b0; #1;
        n_tests++; if (rs1_data !== '0 || rs2_data !== '0) begin n_fail++; $display("FAIL rst_async_rs got %h/%h want 0/0", rs1_data, rs2_data); end
        n_tests++; if (reg_flat !== '0 || retired !== '0 || err_rd !== 1'b0) begin n_fail++; $display("FAIL rst_async_state flat=%h ret=%0d err=%b want 0", reg_flat, retired, err_rd); end
        #1; rst_n = 1'b1; model_reset();
        idle();
        step(); step();
        n_tests++; if (reg_flat[1*DW +: DW] !== 16'h0000 || rs1_data !== 16'h0000) begin n_fail++; $display("FAIL rst_no_commit got %h/%h want 0000", reg_flat[1*DW +: DW], rs1_data); end
        n_tests++; if (retired !== '0) begin n_fail++; $display("FAIL rst_retired got %0d want 0", retired); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_bypass();
        test_back_to_back();
        test_store();
        test_stall();
        test_flush_err();
        test_random();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
